// File: rtl/uart_frame_serializer_if.sv
// uart_frame_serializer_if
//   Groups the converter-side request/data bundle and the serializer status
//   lines so the serializer can be connected with a single port.
//   master : digit converter side (drives request + data, reads status)
//   slave  : serializer side (reads request + data, drives line + status)
//   txTransmit  level request, frame starts on its 0->1 transition
//   result      detection flag
//   imgID       image index 0..7
//   acc_bcd     accuracy {h,t,u}
//   bb1_bcd     {x1 h,t,u, y1 h,t,u}
//   bb2_bcd     {x2 h,t,u, y2 h,t,u}
//   txOut       serial line, idles high
//   txDone      frame complete while txTransmit still high
//   busy        frame in progress
interface uart_frame_serializer_if;
    logic        txTransmit;
    logic        result;
    logic [2:0]  imgID;
    logic [11:0] acc_bcd;
    logic [23:0] bb1_bcd;
    logic [23:0] bb2_bcd;
    logic        txOut;
    logic        txDone;
    logic        busy;

    modport master (
        output txTransmit, result, imgID, acc_bcd, bb1_bcd, bb2_bcd,
        input  txOut, txDone, busy
    );

    modport slave (
        input  txTransmit, result, imgID, acc_bcd, bb1_bcd, bb2_bcd,
        output txOut, txDone, busy
    );
endinterface

// File: rtl/uart_frame_serializer.sv
// uart_frame_serializer
//   Turns one detection result (flag, image ID, BCD accuracy and two bounding
//   box corners) into a 25-byte ASCII line "r,i,aaa,xxx,yyy,xxx,yyy\r\n" and
//   shifts it out as back-to-back UART characters (8N1, LSB first).
//   Ports:
//     clock  system clock, rising edge
//     reset  synchronous active-low reset
//     bus    uart_frame_serializer_if.slave (request, data, line, status)
//   Parameter CLKS_PER_BIT: clock cycles per UART bit (>= 2).
//   Optional macro UART_PARITY_EN: adds an even-parity bit after the data
//   bits (8E1 framing, 11 bits per character).
module uart_frame_serializer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                     clock,
    input  logic                     reset,
    uart_frame_serializer_if.slave   bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LAST_BYTE = 5'd24;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, DATA, STOP, DONE
`ifdef UART_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [4:0]  byte_q, byte_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_prev_q, tx_prev_d;
    logic        res_q, res_d;
    logic [2:0]  img_q, img_d;
    logic [11:0] acc_q, acc_d;
    logic [23:0] bb1_q, bb1_d;
    logic [23:0] bb2_q, bb2_d;
    logic        txout_q, txout_d;
    logic        txdone_q, txdone_d;
    logic        busy_q, busy_d;
`ifdef UART_PARITY_EN
    logic        par_q, par_d;
`endif

    logic        baud_wrap;
    logic [4:0]  nxt_idx;
    logic [7:0]  nxt_byte;

    function automatic logic [7:0] digit(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    // Byte idx of the frame, built from the captured snapshot.
    function automatic logic [7:0] frame_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = {7'b0011000, res_q};
            5'd2:    b = {5'b00110, img_q};
            5'd4:    b = digit(acc_q[11:8]);
            5'd5:    b = digit(acc_q[7:4]);
            5'd6:    b = digit(acc_q[3:0]);
            5'd8:    b = digit(bb1_q[23:20]);
            5'd9:    b = digit(bb1_q[19:16]);
            5'd10:   b = digit(bb1_q[15:12]);
            5'd12:   b = digit(bb1_q[11:8]);
            5'd13:   b = digit(bb1_q[7:4]);
            5'd14:   b = digit(bb1_q[3:0]);
            5'd16:   b = digit(bb2_q[23:20]);
            5'd17:   b = digit(bb2_q[19:16]);
            5'd18:   b = digit(bb2_q[15:12]);
            5'd20:   b = digit(bb2_q[11:8]);
            5'd21:   b = digit(bb2_q[7:4]);
            5'd22:   b = digit(bb2_q[3:0]);
            5'd23:   b = 8'h0D;
            5'd24:   b = 8'h0A;
            default: b = 8'h2C;  // separators at 1,3,7,11,15,19
        endcase
        return b;
    endfunction

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        tx_prev_d = bus.txTransmit;
        res_d     = res_q;
        img_d     = img_q;
        acc_d     = acc_q;
        bb1_d     = bb1_q;
        bb2_d     = bb2_q;
`ifdef UART_PARITY_EN
        par_d     = par_q;
`endif
        baud_wrap = (baud_q == BAUD_MAX);
        // LOAD fetches byte 0; STOP prefetches the following byte.
        nxt_idx   = (state_q == LOAD) ? byte_q : 5'(byte_q + 5'd1);
        nxt_byte  = frame_byte(nxt_idx);

        case (state_q)
            IDLE: begin
                if (bus.txTransmit && !tx_prev_q) begin
                    res_d   = bus.result;
                    img_d   = bus.imgID;
                    acc_d   = bus.acc_bcd;
                    bb1_d   = bus.bb1_bcd;
                    bb2_d   = bus.bb2_bcd;
                    byte_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = nxt_byte;
`ifdef UART_PARITY_EN
                par_d   = ^nxt_byte;
`endif
                bit_d   = '0;
                baud_d  = '0;
                state_d = START;
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (byte_q < LAST_BYTE) begin
                        byte_d  = nxt_idx;
                        shift_d = nxt_byte;
`ifdef UART_PARITY_EN
                        par_d   = ^nxt_byte;
`endif
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DONE: begin
                if (!bus.txTransmit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the current state, so the line lags
        // the state by one cycle; every bit still spans CLKS_PER_BIT cycles.
        txout_d = 1'b1;
        case (state_q)
            START:   txout_d = 1'b0;
            DATA:    txout_d = shift_q[0];
`ifdef UART_PARITY_EN
            PARITY:  txout_d = par_q;
`endif
            default: txout_d = 1'b1;
        endcase
        txdone_d = (state_q == DONE);
        busy_d   = (state_q != IDLE) && (state_q != DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            tx_prev_q <= 1'b0;
            res_q     <= 1'b0;
            img_q     <= '0;
            acc_q     <= '0;
            bb1_q     <= '0;
            bb2_q     <= '0;
            txout_q   <= 1'b1;
            txdone_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            tx_prev_q <= tx_prev_d;
            res_q     <= res_d;
            img_q     <= img_d;
            acc_q     <= acc_d;
            bb1_q     <= bb1_d;
            bb2_q     <= bb2_d;
            txout_q   <= txout_d;
            txdone_q  <= txdone_d;
            busy_q    <= busy_d;
`ifdef UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign bus.txOut  = txout_q;
    assign bus.txDone = txdone_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_frame_serializer.sv
module tb_uart_frame_serializer;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int CHAR_BITS = 11;
`else
    localparam int CHAR_BITS = 10;
`endif
    // busy covers the whole line activity plus the LOAD cycle
    localparam int BUSY_LEN = 25 * CHAR_BITS * CPB + 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_frame_serializer_if bus();

    uart_frame_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int low_cnt  = 0;
    logic [7:0] exp_b [25];

    always @(negedge clock) begin
        if (bus.busy === 1'b1)   busy_cnt++;
        if (bus.txDone === 1'b1) done_cnt++;
        if (bus.txOut === 1'b0)  low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n falling edges, then step off the edge so counters are settled.
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic set_exp(input string s);
        for (int i = 0; i < 23; i++) exp_b[i] = s[i];
        exp_b[23] = 8'h0D;
        exp_b[24] = 8'h0A;
    endtask

    task automatic set_in(input logic r, input logic [2:0] img, input logic [11:0] acc,
                          input logic [23:0] b1, input logic [23:0] b2);
        bus.result  = r;
        bus.imgID   = img;
        bus.acc_bcd = acc;
        bus.bb1_bcd = b1;
        bus.bb2_bcd = b2;
    endtask

    task automatic rx_byte(input string tag, output logic [7:0] b, output bit ok);
        int t;
        t  = 0;
        b  = '0;
        ok = 1'b0;
        while (bus.txOut !== 1'b0 && t < 200) begin
            cyc(1);
            t++;
        end
        chk({tag, "_start"}, {31'b0, bus.txOut}, 32'd0);
        if (bus.txOut !== 1'b0) return;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            cyc(CPB);
            b[i] = bus.txOut;
        end
`ifdef UART_PARITY_EN
        cyc(CPB);
        chk({tag, "_par"}, {31'b0, bus.txOut}, {31'b0, ^b});
`endif
        cyc(CPB);
        chk({tag, "_stop"}, {31'b0, bus.txOut}, 32'd1);
        ok = 1'b1;
    endtask

    task automatic rx_frame(input string tag);
        logic [7:0] b;
        bit ok;
        for (int i = 0; i < 25; i++) begin
            rx_byte($sformatf("%s_b%0d", tag, i), b, ok);
            if (!ok) break;
            chk($sformatf("%s_b%0d", tag, i), {24'b0, b}, {24'b0, exp_b[i]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, d0, l0;
        reset = 1'b0;
        bus.txTransmit = 1'b0;
        set_in(1'b0, 3'd0, 12'h000, 24'h0, 24'h0);

        // reset held low for 3 cycles, then released
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_txout", {31'b0, bus.txOut},  32'd1);
            chk("rst_busy",  {31'b0, bus.busy},   32'd0);
            chk("rst_done",  {31'b0, bus.txDone}, 32'd0);
        end
        reset = 1'b1;
        cyc(2);
        chk("rel_txout", {31'b0, bus.txOut}, 32'd1);
        chk("rel_busy",  {31'b0, bus.busy},  32'd0);
        chk("rel_done",  {31'b0, bus.txDone}, 32'd0);

        // frame 1, request held high throughout
        set_in(1'b1, 3'd3, 12'h987, 24'h012034, 24'h200199);
        set_exp("1,3,987,012,034,200,199");
        b0 = busy_cnt;
        bus.txTransmit = 1'b1;
        rx_frame("f1");
        cyc(10);
        chk("f1_busy_len", busy_cnt - b0, BUSY_LEN);
        chk("f1_done", {31'b0, bus.txDone}, 32'd1);
        chk("f1_busy", {31'b0, bus.busy},   32'd0);

        // request stays high: no retransmission
        l0 = low_cnt;
        cyc(3000);
        chk("hold_low",  low_cnt - l0, 0);
        chk("hold_done", {31'b0, bus.txDone}, 32'd1);
        bus.txTransmit = 1'b0;
        cyc(3);
        chk("drop_done", {31'b0, bus.txDone}, 32'd0);

        // frame 2: invalid BCD nibble, inputs change after capture,
        // request drops mid-frame so txDone only pulses
        set_in(1'b1, 3'd3, 12'hA05, 24'h012034, 24'h200199);
        set_exp("1,3,?05,012,034,200,199");
        d0 = done_cnt;
        bus.txTransmit = 1'b1;
        cyc(1);
        set_in(1'b0, 3'd6, 12'h111, 24'h555555, 24'h666666);
        fork
            rx_frame("f2");
            begin
                cyc(20);
                bus.txTransmit = 1'b0;
            end
        join
        cyc(10);
        chk("f2_done_pulse", done_cnt - d0, 1);
        chk("f2_done", {31'b0, bus.txDone}, 32'd0);
        chk("f2_busy", {31'b0, bus.busy},   32'd0);
        l0 = low_cnt;
        cyc(200);
        chk("f2_no_extra", low_cnt - l0, 0);

        // frame 3 aborted by reset 300 cycles in
        set_in(1'b1, 3'd3, 12'h987, 24'h012034, 24'h200199);
        bus.txTransmit = 1'b1;
        cyc(300);
        chk("f3_busy_mid", {31'b0, bus.busy}, 32'd1);
        reset = 1'b0;
        cyc(1);
        chk("mid_rst_txout", {31'b0, bus.txOut}, 32'd1);
        chk("mid_rst_busy",  {31'b0, bus.busy},  32'd0);
        bus.txTransmit = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        chk("post_rst_busy", {31'b0, bus.busy}, 32'd0);

        // frame 4: full frame after the reset, boundary digits
        set_in(1'b1, 3'd7, 12'h000, 24'h999999, 24'h123456);
        set_exp("1,7,000,999,999,123,456");
        b0 = busy_cnt;
        bus.txTransmit = 1'b1;
        rx_frame("f4");
        cyc(10);
        chk("f4_busy_len", busy_cnt - b0, BUSY_LEN);
        chk("f4_done", {31'b0, bus.txDone}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
